// File: rtl/rat_restore_walker_pkg.sv
// +----------------------------------------------------------------------------+
// | rat_restore_walker_pkg                                                     |
// | Shared ROB / physical-register widths and the walker state encoding.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rat_restore_walker_pkg;

   localparam int c_rob_size         = 64;
   localparam int c_rob_id_width     = $clog2(c_rob_size);
   localparam int c_phy_reg_id_width = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } walker_state_t;

endpackage : rat_restore_walker_pkg

`default_nettype wire

// File: rtl/rat_restore_walker.sv
// +----------------------------------------------------------------------------+
// | rat_restore_walker                                                         |
// | Flush recovery: walks the squashed ROB range youngest-to-oldest, restoring |
// | RAT mappings and releasing squashed physical registers; stalls rename.     |
// | Optional macro RAT_WALKER_PERF_EN adds walker_perf_walk_cycles.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rat_restore_walker
   import rat_restore_walker_pkg::*;
#(
   parameter int ROB_SIZE         = c_rob_size,
   parameter int ROB_ID_WIDTH     = $clog2(ROB_SIZE),
   parameter int PHY_REG_ID_WIDTH = c_phy_reg_id_width
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush_req,
   input  logic [ROB_ID_WIDTH-1:0]     flush_rob_id,
   input  logic [ROB_ID_WIDTH-1:0]     rob_tail_id,
   input  logic                        rob_full,
   output logic [ROB_ID_WIDTH-1:0]     walker_rob_read_id,
   input  logic                        rob_walker_has_dest,
   input  logic [PHY_REG_ID_WIDTH-1:0] rob_walker_new_phy_id,
   input  logic [PHY_REG_ID_WIDTH-1:0] rob_walker_old_phy_id,
   output logic                        walker_rat_restore_map,
   output logic [PHY_REG_ID_WIDTH-1:0] walker_rat_restore_new_phy_id,
   output logic [PHY_REG_ID_WIDTH-1:0] walker_rat_restore_old_phy_id,
   output logic                        walker_freelist_release_valid,
   output logic [PHY_REG_ID_WIDTH-1:0] walker_freelist_release_phy_id,
   output logic                        walker_rename_stall,
   output logic                        walker_flush_done
`ifdef RAT_WALKER_PERF_EN
   ,
   output logic [31:0]                 walker_perf_walk_cycles
`endif
);

   localparam logic [ROB_ID_WIDTH:0] c_full_count = (ROB_ID_WIDTH+1)'(ROB_SIZE);

   walker_state_t             r_state;
   walker_state_t             w_next_state;
   logic [ROB_ID_WIDTH-1:0]   r_ptr;
   logic [ROB_ID_WIDTH-1:0]   w_next_ptr;
   logic [ROB_ID_WIDTH:0]     r_remaining;
   logic [ROB_ID_WIDTH:0]     w_next_remaining;

   logic [ROB_ID_WIDTH-1:0]   w_start_ptr;
   logic [ROB_ID_WIDTH-1:0]   w_range_diff;
   logic [ROB_ID_WIDTH:0]     w_start_remaining;

   // Equal head/tail is ambiguous: only rob_full distinguishes full from empty.
   assign w_start_ptr       = rob_tail_id - ROB_ID_WIDTH'(1);
   assign w_range_diff      = rob_tail_id - flush_rob_id;
   assign w_start_remaining = (rob_full && (rob_tail_id == flush_rob_id))
                              ? c_full_count : {1'b0, w_range_diff};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_remaining <= '0;
      end else begin
         r_state     <= w_next_state;
         r_ptr       <= w_next_ptr;
         r_remaining <= w_next_remaining;
      end
   end

   always_comb begin
      w_next_state                   = r_state;
      w_next_ptr                     = r_ptr;
      w_next_remaining               = r_remaining;
      walker_rob_read_id             = r_ptr;
      walker_rat_restore_map         = 1'b0;
      walker_rat_restore_new_phy_id  = '0;
      walker_rat_restore_old_phy_id  = '0;
      walker_freelist_release_valid  = 1'b0;
      walker_freelist_release_phy_id = '0;
      walker_rename_stall            = (r_state != ST_IDLE);
      walker_flush_done              = (r_state == ST_DONE);

      case (r_state)
         ST_IDLE: begin
            if (flush_req) begin
               w_next_ptr       = w_start_ptr;
               w_next_remaining = w_start_remaining;
               w_next_state     = (w_start_remaining == '0) ? ST_DONE : ST_WALK;
            end
         end
         ST_WALK: begin
            if (rob_walker_has_dest) begin
               walker_rat_restore_map         = 1'b1;
               walker_rat_restore_new_phy_id  = rob_walker_new_phy_id;
               walker_rat_restore_old_phy_id  = rob_walker_old_phy_id;
               walker_freelist_release_valid  = 1'b1;
               walker_freelist_release_phy_id = rob_walker_new_phy_id;
            end
            w_next_ptr       = r_ptr - ROB_ID_WIDTH'(1);
            w_next_remaining = r_remaining - (ROB_ID_WIDTH+1)'(1);
            if (r_remaining == (ROB_ID_WIDTH+1)'(1)) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

`ifdef RAT_WALKER_PERF_EN
   logic [31:0] r_perf_walk_cycles;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_perf_walk_cycles <= '0;
      end else if ((r_state == ST_WALK) && (r_perf_walk_cycles != '1)) begin
         r_perf_walk_cycles <= r_perf_walk_cycles + 32'd1;
      end
   end

   assign walker_perf_walk_cycles = r_perf_walk_cycles;
`endif

endmodule : rat_restore_walker

`default_nettype wire

// File: tb/tb_rat_restore_walker.sv
// +----------------------------------------------------------------------------+
// | tb_rat_restore_walker                                                      |
// | Directed self-checking bench for rat_restore_walker.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rat_restore_walker;

   localparam int RW = 6;
   localparam int PW = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_req;
   logic [RW-1:0] flush_rob_id;
   logic [RW-1:0] rob_tail_id;
   logic          rob_full;
   logic [RW-1:0] rd_id;
   logic          rob_has;
   logic [PW-1:0] rob_new;
   logic [PW-1:0] rob_old;
   logic          rs_map;
   logic [PW-1:0] rs_new;
   logic [PW-1:0] rs_old;
   logic          rel_v;
   logic [PW-1:0] rel_id;
   logic          stall;
   logic          done;
`ifdef RAT_WALKER_PERF_EN
   logic [31:0]   perf;
   logic [31:0]   perf_before;
`endif

   int checks   = 0;
   int failures = 0;
   int nodest_id = -1;

   always #5 clk = ~clk;

   // ROB model: contents derived from the entry index
   always_comb begin
      rob_has = (int'(rd_id) != nodest_id);
      rob_new = {1'b1, rd_id};
      rob_old = {1'b0, rd_id} ^ 7'h2A;
   end

   rat_restore_walker dut (
      .clk                            (clk),
      .rst                            (rst),
      .flush_req                      (flush_req),
      .flush_rob_id                   (flush_rob_id),
      .rob_tail_id                    (rob_tail_id),
      .rob_full                       (rob_full),
      .walker_rob_read_id             (rd_id),
      .rob_walker_has_dest            (rob_has),
      .rob_walker_new_phy_id          (rob_new),
      .rob_walker_old_phy_id          (rob_old),
      .walker_rat_restore_map         (rs_map),
      .walker_rat_restore_new_phy_id  (rs_new),
      .walker_rat_restore_old_phy_id  (rs_old),
      .walker_freelist_release_valid  (rel_v),
      .walker_freelist_release_phy_id (rel_id),
      .walker_rename_stall            (stall),
      .walker_flush_done              (done)
`ifdef RAT_WALKER_PERF_EN
      ,
      .walker_perf_walk_cycles        (perf)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_walk(input string tag, input logic [RW-1:0] id, input logic has);
      chk({tag, ".read_id"}, 64'(rd_id), 64'(id));
      chk({tag, ".restore_map"}, 64'(rs_map), 64'(has));
      chk({tag, ".release_valid"}, 64'(rel_v), 64'(has));
      if (has) begin
         chk({tag, ".restore_new"}, 64'(rs_new), 64'({1'b1, id}));
         chk({tag, ".restore_old"}, 64'(rs_old), 64'({1'b0, id} ^ 7'h2A));
         chk({tag, ".release_id"}, 64'(rel_id), 64'({1'b1, id}));
      end
      chk({tag, ".stall"}, 64'(stall), 64'd1);
      chk({tag, ".done"}, 64'(done), 64'd0);
   endtask

   task automatic chk_quiet(input string tag, input logic exp_done, input logic exp_stall);
      chk({tag, ".restore_map"}, 64'(rs_map), 64'd0);
      chk({tag, ".release_valid"}, 64'(rel_v), 64'd0);
      chk({tag, ".restore_new"}, 64'(rs_new), 64'd0);
      chk({tag, ".restore_old"}, 64'(rs_old), 64'd0);
      chk({tag, ".release_id"}, 64'(rel_id), 64'd0);
      chk({tag, ".done"}, 64'(done), 64'(exp_done));
      chk({tag, ".stall"}, 64'(stall), 64'(exp_stall));
   endtask

   task automatic start_flush(input logic [RW-1:0] tail, input logic [RW-1:0] fid, input logic full);
      rob_tail_id  = tail;
      flush_rob_id = fid;
      rob_full     = full;
      flush_req    = 1'b1;
      #1;
      chk("cycleN.stall", 64'(stall), 64'd0);
      tick();
      flush_req = 1'b0;
   endtask

   initial begin
      rst          = 1'b0;
      flush_req    = 1'b1;
      flush_rob_id = 6'd0;
      rob_tail_id  = 6'd8;
      rob_full     = 1'b0;

      // Reset with flush_req held high: must be ignored
      tick();
      tick();
      chk_quiet("reset", 1'b0, 1'b0);
      chk("reset.read_id", 64'(rd_id), 64'd0);
      rst       = 1'b1;
      flush_req = 1'b0;
      tick();
      chk_quiet("post_reset", 1'b0, 1'b0);

      // Walk of 3, with ignored flush_req in WALK and DONE
      start_flush(6'd5, 6'd2, 1'b0);
      chk_walk("w3.c1", 6'd4, 1'b1);
      tick();
      chk_walk("w3.c2", 6'd3, 1'b1);
      flush_req    = 1'b1;
      rob_tail_id  = 6'd40;
      flush_rob_id = 6'd30;
      tick();
      flush_req = 1'b0;
      chk_walk("w3.c3", 6'd2, 1'b1);
      tick();
      chk_quiet("w3.done", 1'b1, 1'b1);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      chk_quiet("w3.idle", 1'b0, 1'b0);
      tick();
      chk_quiet("w3.idle2", 1'b0, 1'b0);

      // Wrap around entry 0
      start_flush(6'd1, 6'd62, 1'b0);
      chk_walk("wrap.c1", 6'd0, 1'b1);
      tick();
      chk_walk("wrap.c2", 6'd63, 1'b1);
      tick();
      chk_walk("wrap.c3", 6'd62, 1'b1);
      tick();
      chk_quiet("wrap.done", 1'b1, 1'b1);
      tick();
      chk_quiet("wrap.idle", 1'b0, 1'b0);

      // Entry 3 has no destination
      nodest_id = 3;
      start_flush(6'd5, 6'd2, 1'b0);
      chk_walk("mix.c1", 6'd4, 1'b1);
      tick();
      chk_walk("mix.c2", 6'd3, 1'b0);
      tick();
      chk_walk("mix.c3", 6'd2, 1'b1);
      tick();
      chk_quiet("mix.done", 1'b1, 1'b1);
      tick();
      chk_quiet("mix.idle", 1'b0, 1'b0);
      nodest_id = -1;

      // Empty range
      start_flush(6'd20, 6'd20, 1'b0);
      chk_quiet("empty.done", 1'b1, 1'b1);
      chk("empty.read_id", 64'(rd_id), 64'd19);
      tick();
      chk_quiet("empty.idle", 1'b0, 1'b0);

      // Full ROB: 64 entries starting at tail-1 = 9
`ifdef RAT_WALKER_PERF_EN
      perf_before = perf;
`endif
      start_flush(6'd10, 6'd10, 1'b1);
      for (int i = 0; i < 64; i++) begin
         chk_walk("full", RW'(9 - i), 1'b1);
         tick();
      end
      chk_quiet("full.done", 1'b1, 1'b1);
      tick();
      chk_quiet("full.idle", 1'b0, 1'b0);
`ifdef RAT_WALKER_PERF_EN
      chk("full.perf", 64'(perf), 64'(perf_before + 32'd64));
`endif

      // Abort with reset at walk cycle 2
      start_flush(6'd5, 6'd2, 1'b0);
      chk_walk("abort.c1", 6'd4, 1'b1);
      tick();
      chk_walk("abort.c2", 6'd3, 1'b1);
      rst = 1'b0;
      tick();
      chk_quiet("abort.rst", 1'b0, 1'b0);
      chk("abort.read_id", 64'(rd_id), 64'd0);
      rst = 1'b1;
      tick();
      chk_quiet("abort.after", 1'b0, 1'b0);
      tick();
      chk_quiet("abort.after2", 1'b0, 1'b0);

      // New flush after abort is accepted
      start_flush(6'd7, 6'd5, 1'b0);
      chk_walk("re.c1", 6'd6, 1'b1);
      tick();
      chk_walk("re.c2", 6'd5, 1'b1);
      tick();
      chk_quiet("re.done", 1'b1, 1'b1);
      tick();
      chk_quiet("re.idle", 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rat_restore_walker

`default_nettype wire
